// File: rtl/msk_aes_share_loader_if.sv
// msk_aes_share_loader_if
//   Bundles the upstream beat stream and the masked-core hand-off of the
//   share loader.
//   d             : number of shares per bit
//   s_valid/s_ready/s_data : upstream 32-bit beats, bit-compact shares
//                   (bit b, share j at index b*d+j)
//   busy          : loader holds beats or a pending transaction
//   core_valid_in/core_in_ready : hand-off to the masked AES core
//   sh_plaintext/sh_key : 128-bit sharings presented to the core
//   slave modport : loader side; master modport : source/core side.
interface msk_aes_share_loader_if #(
    parameter int d = 2
);
    logic               s_valid;
    logic               s_ready;
    logic [32*d-1:0]    s_data;
    logic               busy;
    logic               core_valid_in;
    logic               core_in_ready;
    logic [128*d-1:0]   sh_plaintext;
    logic [128*d-1:0]   sh_key;

    modport slave (
        input  s_valid, s_data, core_in_ready,
        output s_ready, busy, core_valid_in, sh_plaintext, sh_key
    );

    modport master (
        output s_valid, s_data, core_in_ready,
        input  s_ready, busy, core_valid_in, sh_plaintext, sh_key
    );
endinterface

// File: rtl/msk_aes_share_loader.sv
// msk_aes_share_loader
//   Input stage for the 32-bit masked AES core. Collects 4 plaintext beats
//   then 4 key beats (least-significant word first) and presents the full
//   sharings through the core's valid_in/in_ready handshake. Data paths are
//   purely share-wise (register, mux, zero); shares are never combined.
//   Ports:
//     clk      : clock, rising edge
//     rst      : asynchronous reset, active low
//     load_key : (only with MSK_LOADER_KEY_REUSE_EN) sampled on beat 0;
//                0 skips the key beats and reuses the stored key sharing
//     bus      : msk_aes_share_loader_if.slave (stream in, core out)
//   Optional feature macro: MSK_LOADER_KEY_REUSE_EN
module msk_aes_share_loader #(
    parameter int d = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef MSK_LOADER_KEY_REUSE_EN
    input  logic load_key,
`endif
    msk_aes_share_loader_if.slave bus
);

    typedef enum logic [1:0] {
        LOAD_PT  = 2'd0,
        LOAD_KEY = 2'd1,
        PRESENT  = 2'd2
    } state_e;

    state_e            state;
    logic [2:0]        cnt;
    logic [128*d-1:0]  pt_q;
    logic [128*d-1:0]  key_q;
    logic              present;
`ifdef MSK_LOADER_KEY_REUSE_EN
    logic              key_flag;
`endif

    assign present = (state == PRESENT);

    // Ready is masked by reset so nothing is consumed while rst is low.
    assign bus.s_ready       = rst & ~present;
    assign bus.core_valid_in = present;
    assign bus.busy          = (state != LOAD_PT) || (cnt != 3'd0);

    // A partially loaded sharing never reaches the core.
    assign bus.sh_plaintext  = present ? pt_q  : '0;
    assign bus.sh_key        = present ? key_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD_PT;
            cnt   <= 3'd0;
            pt_q  <= '0;
            key_q <= '0;
`ifdef MSK_LOADER_KEY_REUSE_EN
            key_flag <= 1'b1;
`endif
        end else if (present) begin
            if (bus.core_in_ready) begin
                state <= LOAD_PT;
                cnt   <= 3'd0;
                pt_q  <= '0;
`ifndef MSK_LOADER_KEY_REUSE_EN
                key_q <= '0;
`endif
            end
        end else if (bus.s_valid) begin
            // Load states always have s_ready high here (rst is high).
            for (int k = 0; k < 4; k++) begin
                if (cnt[1:0] == 2'(k)) begin
                    if (!cnt[2]) pt_q[k*32*d +: 32*d]  <= bus.s_data;
                    else         key_q[k*32*d +: 32*d] <= bus.s_data;
                end
            end
            cnt <= cnt + 3'd1;  // 7 -> 0 wrap coincides with entering PRESENT
`ifdef MSK_LOADER_KEY_REUSE_EN
            if (cnt == 3'd0) key_flag <= load_key;
            if (cnt == 3'd3) begin
                if (!key_flag) begin
                    state <= PRESENT;
                    cnt   <= 3'd0;
                end else begin
                    state <= LOAD_KEY;
                end
            end
`else
            if (cnt == 3'd3) state <= LOAD_KEY;
`endif
            if (cnt == 3'd7) state <= PRESENT;
        end
    end

endmodule
